// File: rtl/regfile_scoreboard_pkg.sv
// Shared types for the integer register file and the WB commit bundle.
// Holds the word/address types and the pending-counter sizing used by decode and WB.
package regfile_scoreboard_pkg;

    localparam int unsigned XLEN_C   = 64;
    localparam int unsigned NREG_C   = 32;
    localparam int unsigned PEND_W_C = 2;
    localparam int unsigned RADDR_W  = 5;

    typedef logic [XLEN_C-1:0]   word_t;
    typedef logic [RADDR_W-1:0]  reg_addr;
    typedef logic                bool;
    typedef logic [PEND_W_C-1:0] pend_cnt_t;

    // release is a keyword, hence the _en suffix on the release strobe
    typedef struct packed {
        bool     valid;
        bool     wen;
        reg_addr dest;
        word_t   data;
        bool     release_en;
        reg_addr release_addr;
    } wb_commit_t;

endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// Saturating up/down counter tracking in-flight writers of one register.
// A simultaneous inc and dec leaves the count unchanged.
module regfile_scoreboard_pend_counter #(
    parameter int unsigned PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt,
    output logic              full,
    output logic              nonzero
);

    assign full    = (cnt == '1);
    assign nonzero = (cnt != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && nonzero) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A release with nothing in flight is a decode/WB protocol error; the count holds at 0
    always_ff @(posedge clk) begin
        if (reset && dec && !inc) begin
            release_underflow: assert (nonzero);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with WB-to-read bypass, per-register pending
// counters for RAW stalls, and a retired-instruction counter.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned NREG   = NREG_C,
    parameter int unsigned XLEN   = XLEN_C,
    parameter int unsigned PEND_W = PEND_W_C
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid,
    input  logic            wb_reg_write_enable,
    input  logic [4:0]      wb_reg_dest_addr,
    input  logic [XLEN-1:0] wb_reg_write_data,
    input  logic            wb_release,
    input  logic [4:0]      wb_release_addr,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    output logic [63:0]     instret
);

    wb_commit_t wb;
    logic [XLEN-1:0]   regs [NREG];
    logic [PEND_W-1:0] cnts [NREG];
    logic [NREG-1:0]   full_v;
    logic [NREG-1:0]   nz_v;
    logic [NREG-1:0]   inc_v;
    logic [NREG-1:0]   dec_v;
    logic              wb_write;

    always_comb begin
        wb              = '0;
        wb.valid        = wb_valid;
        wb.wen          = wb_reg_write_enable;
        wb.dest         = wb_reg_dest_addr;
        wb.data         = wb_reg_write_data[XLEN_C-1:0];
        wb.release_en   = wb_release;
        wb.release_addr = wb_release_addr;
    end

    assign wb_write = wb.valid && wb.wen && (wb.dest != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[wb.dest] <= wb.data;
        end
    end

    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = (wb_write && wb.dest == rs1_addr) ? wb.data : regs[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            rs2_data = (wb_write && wb.dest == rs2_addr) ? wb.data : regs[rs2_addr];
        end
    end

    always_comb begin
        dec_v = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            dec_v[r] = wb.release_en && (wb.release_addr == reg_addr'(r));
        end
    end

    // Ready depends only on the counter state and releases, so inc has no loop back into it
    assign issue_ready = !((issue_rd != '0) && full_v[issue_rd] && !dec_v[issue_rd]);

    always_comb begin
        inc_v = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            inc_v[r] = issue_valid && issue_ready && (issue_rd == reg_addr'(r));
        end
    end

    assign cnts[0]   = '0;
    assign full_v[0] = 1'b0;
    assign nz_v[0]   = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_pend
        regfile_scoreboard_pend_counter #(
            .PEND_W (PEND_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc     (inc_v[g]),
            .dec     (dec_v[g]),
            .cnt     (cnts[g]),
            .full    (full_v[g]),
            .nonzero (nz_v[g])
        );
    end

    // Busy is (cnt - dec) != 0, so the releasing cycle already reads as not busy
    assign rs1_busy = nz_v[rs1_addr] ? !(dec_v[rs1_addr] && cnts[rs1_addr] == PEND_W'(1))
                                     : dec_v[rs1_addr];
    assign rs2_busy = nz_v[rs2_addr] ? !(dec_v[rs2_addr] && cnts[rs2_addr] == PEND_W'(1))
                                     : dec_v[rs2_addr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            instret <= '0;
        end else if (wb.valid) begin
            instret <= instret + 64'd1;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: expectations are queued as
// stimulus is driven and popped when the DUT outputs are sampled.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_reg_write_enable = 1'b0;
    logic [4:0]  wb_reg_dest_addr = '0;
    logic [63:0] wb_reg_write_data = '0;
    logic        wb_release = 1'b0;
    logic [4:0]  wb_release_addr = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic [63:0] instret;

    logic [63:0] exp_q [$];
    logic [63:0] exp_v;
    logic [63:0] model_ret = '0;
    int n_vec = 0;
    int n_err = 0;

    regfile_scoreboard #(
        .NREG   (32),
        .XLEN   (64),
        .PEND_W (2)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .wb_valid            (wb_valid),
        .wb_reg_write_enable (wb_reg_write_enable),
        .wb_reg_dest_addr    (wb_reg_dest_addr),
        .wb_reg_write_data   (wb_reg_write_data),
        .wb_release          (wb_release),
        .wb_release_addr     (wb_release_addr),
        .rs1_addr            (rs1_addr),
        .rs2_addr            (rs2_addr),
        .rs1_data            (rs1_data),
        .rs2_data            (rs2_data),
        .rs1_busy            (rs1_busy),
        .rs2_busy            (rs2_busy),
        .issue_valid         (issue_valid),
        .issue_rd            (issue_rd),
        .issue_ready         (issue_ready),
        .instret             (instret)
    );

    always #5 clk = ~clk;

    // Advance through one rising edge, updating the retire model from the inputs it will see
    task automatic tick();
        if (!reset) model_ret = '0;
        else if (wb_valid) model_ret = model_ret + 64'd1;
        @(negedge clk);
    endtask

    task automatic idle();
        wb_valid = 1'b0; wb_reg_write_enable = 1'b0; wb_reg_dest_addr = '0;
        wb_reg_write_data = '0; wb_release = 1'b0; wb_release_addr = '0;
        issue_valid = 1'b0; issue_rd = '0;
    endtask

    task automatic commit(input logic [4:0] d, input logic [63:0] v);
        wb_valid = 1'b1; wb_reg_write_enable = 1'b1; wb_reg_dest_addr = d; wb_reg_write_data = v;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        commit(5'd5, 64'hDEAD);
        tick();
        tick();
        reset = 1'b1;
        idle();
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        exp_q.push_back(model_ret); exp_q.push_back(64'd1);
        #1;
        n_vec++; exp_v = exp_q.pop_front();
        if (rs1_data !== exp_v) begin n_err++; $display("FAIL reset_rs1_data: got %h expected %h", rs1_data, exp_v); end
        n_vec++; exp_v = exp_q.pop_front();
        if ({63'd0, rs1_busy} !== exp_v) begin n_err++; $display("FAIL reset_rs1_busy: got %b expected %0d", rs1_busy, exp_v); end
        n_vec++; exp_v = exp_q.pop_front();
        if (instret !== exp_v) begin n_err++; $display("FAIL reset_instret: got %0d expected %0d", instret, exp_v); end
        n_vec++; exp_v = exp_q.pop_front();
        if ({63'd0, issue_ready} !== exp_v) begin n_err++; $display("FAIL reset_issue_ready: got %b expected %0d", issue_ready, exp_v); end
    endtask

    task automatic test_write_bypass();
        commit(5'd3, 64'h1234);
        rs1_addr = 5'd3;
        exp_q.push_back(64'h1234);
        #1;
        n_vec++; exp_v = exp_q.pop_front();
        if (rs1_data !== exp_v) begin n_err++; $display("FAIL bypass_same_cycle: got %h expected %h", rs1_data, exp_v); end
        tick();
        idle();
        rs1_addr = 5'd3;
        exp_q.push_back(64'h1234); exp_q.push_back(model_ret);
        #1;
        n_vec++; exp_v = exp_q.pop_front();
        if (rs1_data !== exp_v) begin n_err++; $display("FAIL write_next_cycle: got %h expected %h", rs1_data, exp_v); end
        n_vec++; exp_v = exp_q.pop_front();
        if (instret !== exp_v) begin n_err++; $display("FAIL write_instret: got %0d expected %0d", instret, exp_v); end
    endtask

    task automatic test_x0();
        commit(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        issue_valid = 1'b1; issue_rd = 5'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        exp_q.push_back(64'd0); exp_q.push_back(64'd1);
        #1;
        n_vec++; exp_v = exp_q.pop_front();
        if (rs1_data !== exp_v) begin n_err++; $display("FAIL x0_bypass: got %h expected %h", rs1_data, exp_v); end
        n_vec++; exp_v = exp_q.pop_front();
        if ({63'd0, issue_ready} !== exp_v) begin n_err++; $display("FAIL x0_issue_ready: got %b expected %0d", issue_ready, exp_v); end
        tick();
        idle();
        exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        n_vec++; exp_v = exp_q.pop_front();
        if (rs2_data !== exp_v) begin n_err++; $display("FAIL x0_read_after: got %h expected %h", rs2_data, exp_v); end
        n_vec++; exp_v = exp_q.pop_front();
        if ({63'd0, rs2_busy} !== exp_v) begin n_err++; $display("FAIL x0_busy: got %b expected %0d", rs2_busy, exp_v); end
    endtask

    task automatic test_scoreboard();
        int c7 = 0;
        idle();
        rs2_addr = 5'd7;
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1'b1; issue_rd = 5'd7;
            exp_q.push_back({63'd0, c7 != 3});
            #1;
            n_vec++; exp_v = exp_q.pop_front();
            if ({63'd0, issue_ready} !== exp_v) begin n_err++; $display("FAIL sb_issue%0d_ready: got %b expected %0d", k, issue_ready, exp_v); end
            tick();
            c7++;
        end
        exp_q.push_back({63'd0, c7 != 3}); exp_q.push_back({63'd0, c7 != 0});
        #1;
        n_vec++; exp_v = exp_q.pop_front();
        if ({63'd0, issue_ready} !== exp_v) begin n_err++; $display("FAIL sb_saturated_ready: got %b expected %0d", issue_ready, exp_v); end
        n_vec++; exp_v = exp_q.pop_front();
        if ({63'd0, rs2_busy} !== exp_v) begin n_err++; $display("FAIL sb_busy_full: got %b expected %0d", rs2_busy, exp_v); end
        wb_release = 1'b1; wb_release_addr = 5'd7;
        exp_q.push_back(64'd1);
        #1;
        n_vec++; exp_v = exp_q.pop_front();
        if ({63'd0, issue_ready} !== exp_v) begin n_err++; $display("FAIL sb_release_ready: got %b expected %0d", issue_ready, exp_v); end
        tick();
        issue_valid = 1'b0; wb_release = 1'b0;
        exp_q.push_back({63'd0, c7 != 3});
        #1;
        n_vec++; exp_v = exp_q.pop_front();
        if ({63'd0, issue_ready} !== exp_v) begin n_err++; $display("FAIL sb_cnt_held: got %b expected %0d", issue_ready, exp_v); end
        for (int k = 0; k < 3; k++) begin
            wb_release = 1'b1; wb_release_addr = 5'd7;
            exp_q.push_back({63'd0, (c7 - 1) != 0});
            #1;
            n_vec++; exp_v = exp_q.pop_front();
            if ({63'd0, rs2_busy} !== exp_v) begin n_err++; $display("FAIL sb_release%0d_busy: got %b expected %0d", k, rs2_busy, exp_v); end
            tick();
            c7--;
        end
        idle();
        exp_q.push_back(64'd0); exp_q.push_back(64'd1);
        #1;
        n_vec++; exp_v = exp_q.pop_front();
        if ({63'd0, rs2_busy} !== exp_v) begin n_err++; $display("FAIL sb_drained_busy: got %b expected %0d", rs2_busy, exp_v); end
        issue_rd = 5'd7;
        #1;
        n_vec++; exp_v = exp_q.pop_front();
        if ({63'd0, issue_ready} !== exp_v) begin n_err++; $display("FAIL sb_drained_ready: got %b expected %0d", issue_ready, exp_v); end
        issue_rd = 5'd0;
    endtask

    task automatic test_squash();
        logic [63:0] ret_before;
        commit(5'd9, 64'hABC);
        tick();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        idle();
        wb_reg_write_enable = 1'b1; wb_reg_dest_addr = 5'd9; wb_reg_write_data = 64'h5555;
        wb_release = 1'b1; wb_release_addr = 5'd9;
        rs1_addr = 5'd9;
        ret_before = model_ret;
        exp_q.push_back(64'd0); exp_q.push_back(64'hABC);
        #1;
        n_vec++; exp_v = exp_q.pop_front();
        if ({63'd0, rs1_busy} !== exp_v) begin n_err++; $display("FAIL squash_busy: got %b expected %0d", rs1_busy, exp_v); end
        n_vec++; exp_v = exp_q.pop_front();
        if (rs1_data !== exp_v) begin n_err++; $display("FAIL squash_no_bypass: got %h expected %h", rs1_data, exp_v); end
        tick();
        idle();
        exp_q.push_back(64'hABC); exp_q.push_back(ret_before); exp_q.push_back(64'd0);
        #1;
        n_vec++; exp_v = exp_q.pop_front();
        if (rs1_data !== exp_v) begin n_err++; $display("FAIL squash_reg_kept: got %h expected %h", rs1_data, exp_v); end
        n_vec++; exp_v = exp_q.pop_front();
        if (instret !== exp_v) begin n_err++; $display("FAIL squash_instret: got %0d expected %0d", instret, exp_v); end
        n_vec++; exp_v = exp_q.pop_front();
        if ({63'd0, rs1_busy} !== exp_v) begin n_err++; $display("FAIL squash_busy_after: got %b expected %0d", rs1_busy, exp_v); end
    endtask

    task automatic test_instret();
        logic [63:0] base;
        base = model_ret;
        for (int i = 0; i < 14; i++) begin
            idle();
            wb_valid = !(i == 2 || i == 5 || i == 9 || i == 12);
            tick();
        end
        idle();
        exp_q.push_back(base + 64'd10);
        #1;
        n_vec++; exp_v = exp_q.pop_front();
        if (instret !== exp_v) begin n_err++; $display("FAIL instret_ten: got %0d expected %0d", instret, exp_v); end
        @(negedge clk);
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret;
        model_ret = 64'hFFFF_FFFF_FFFF_FFFF;
        commit(5'd4, 64'h77);
        tick();
        idle();
        exp_q.push_back(64'd0); exp_q.push_back(model_ret);
        #1;
        n_vec++; exp_v = exp_q.pop_front();
        if (instret !== exp_v) begin n_err++; $display("FAIL instret_wrap: got %0d expected %0d", instret, exp_v); end
        rs2_addr = 5'd4;
        #1;
        n_vec++; exp_v = exp_q.pop_front();
        if (instret !== exp_v) begin n_err++; $display("FAIL instret_model: got %0d expected %0d", instret, exp_v); end
        exp_q.push_back(64'h77);
        n_vec++; exp_v = exp_q.pop_front();
        if (rs2_data !== exp_v) begin n_err++; $display("FAIL wrap_commit_data: got %h expected %h", rs2_data, exp_v); end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_x0();
        test_scoreboard();
        test_squash();
        test_instret();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule
